// File: rtl/rng_entropy_buffer.sv
// Entropy conditioning stage: whitens chaos x/y/z samples, discards a warm-up burst,
// applies a repetition-count health test and queues accepted words in a FWFT FIFO.
module rng_entropy_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WARMUP    = 16,
    parameter int unsigned REP_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       sample_vld,
    input  logic [31:0]                x_i,
    input  logic [31:0]                y_i,
    input  logic [31:0]                z_i,
    input  logic                       pop,
    input  logic                       clr_fail,
    output logic [31:0]                rd_data,
    output logic                       rd_vld,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       overflow,
    output logic                       health_fail,
    output logic [1:0]                 state_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWarmup = 2'd1,
        StRun    = 2'd2,
        StFail   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     warm_q, warm_d;
    logic [RW-1:0]   rep_q, rep_d, rep_inc;
    logic [31:0]     last_q, last_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     w;
    logic            push, flush, ovf_set, do_pop, is_full;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;

    always_comb begin
        w       = x_i ^ {y_i[15:0], y_i[31:16]} ^ {z_i[7:0], z_i[31:8]};
        rep_inc = (w == last_q) ? rep_q + RW'(1) : RW'(1);
        is_full = (level_q == LW'(DEPTH));
        do_pop  = pop && (level_q != '0) && (state_q != StFail);

        state_d = state_q;
        warm_d  = warm_q;
        rep_d   = rep_q;
        last_d  = last_q;
        push    = 1'b0;
        flush   = 1'b0;
        ovf_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StWarmup;
                    warm_d  = '0;
                end
            end
            StWarmup: begin
                if (!en) begin
                    state_d = StIdle;
                    warm_d  = '0;
                    rep_d   = '0;
                end else if (sample_vld) begin
                    warm_d = warm_q + 16'd1;
                    last_d = w;
                    rep_d  = RW'(1);
                    if (warm_q + 16'd1 == 16'(WARMUP)) state_d = StRun;
                end
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    warm_d  = '0;
                    rep_d   = '0;
                end else if (sample_vld) begin
                    last_d = w;
                    rep_d  = rep_inc;
                    if (rep_inc >= RW'(REP_LIMIT)) begin
                        state_d = StFail;
                        flush   = 1'b1;
                    end else if (!is_full || pop) begin
                        push = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            StFail: begin
                if (clr_fail) begin
                    state_d = StWarmup;
                    warm_d  = '0;
                    rep_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ovf_set)       ovf_d = 1'b1;
        else if (clr_fail) ovf_d = 1'b0;
        else               ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            warm_q  <= '0;
            rep_q   <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            rep_q   <= rep_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: rd_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr_q] <= w;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !do_pop)      level_q <= level_q + LW'(1);
            else if (!push && do_pop) level_q <= level_q - LW'(1);
        end
    end

    always_comb begin
        rd_data     = (level_q != '0) ? mem[rd_ptr_q] : 32'h0;
        rd_vld      = (level_q != '0);
        level       = level_q;
        full        = is_full;
        overflow    = ovf_q;
        health_fail = (state_q == StFail);
        state_o     = state_q;
    end

endmodule

// File: tb/tb_rng_entropy_buffer.sv
// Directed plus randomized bench for rng_entropy_buffer against a queue-based reference model.
module tb_rng_entropy_buffer;

    localparam int DEPTH     = 8;
    localparam int WARMUP    = 16;
    localparam int REP_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst, en, sample_vld, pop, clr_fail;
    logic [31:0] x_i, y_i, z_i;
    logic [31:0] rd_data;
    logic        rd_vld, full, overflow, health_fail;
    logic [3:0]  level;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_st, m_warm, m_rep;
    logic [31:0] m_last;
    bit          m_ovf;
    logic [31:0] q[$];

    rng_entropy_buffer #(.DEPTH(DEPTH), .WARMUP(WARMUP), .REP_LIMIT(REP_LIMIT)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_vld(sample_vld),
        .x_i(x_i), .y_i(y_i), .z_i(z_i), .pop(pop), .clr_fail(clr_fail),
        .rd_data(rd_data), .rd_vld(rd_vld), .level(level), .full(full),
        .overflow(overflow), .health_fail(health_fail), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] whiten(input logic [31:0] x, y, z);
        return x ^ ((y >> 16) | (y << 16)) ^ ((z >> 8) | (z << 24));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, e, v, input logic [31:0] wv, input bit p, c);
        bit popd, psh, fl;
        int pre;
        popd = p && (q.size() > 0) && (m_st != 3);
        pre  = q.size();
        psh  = 0;
        fl   = 0;
        if (r) begin
            m_st = 0; m_warm = 0; m_rep = 0; m_last = 0; m_ovf = 0;
            q.delete();
            return;
        end
        case (m_st)
            0: if (e) begin m_st = 1; m_warm = 0; end
            1: begin
                if (!e) begin m_st = 0; m_warm = 0; m_rep = 0; end
                else if (v) begin
                    m_warm++; m_last = wv; m_rep = 1;
                    if (m_warm == WARMUP) m_st = 2;
                end
            end
            2: begin
                if (!e) begin m_st = 0; m_warm = 0; m_rep = 0; end
                else if (v) begin
                    m_rep  = (wv == m_last) ? m_rep + 1 : 1;
                    m_last = wv;
                    if (m_rep >= REP_LIMIT) begin m_st = 3; fl = 1; end
                    else if (pre < DEPTH || p) psh = 1;
                    else m_ovf = 1;
                end
            end
            default: if (c) begin m_st = 1; m_warm = 0; m_rep = 0; m_ovf = 0; end
        endcase
        if (popd) void'(q.pop_front());
        if (psh) q.push_back(wv);
        if (fl) q.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_data"}, rd_data, (q.size() > 0) ? q[0] : 32'h0);
        chk({tag, ".rd_vld"}, 32'(rd_vld), 32'(q.size() > 0));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".health_fail"}, 32'(health_fail), 32'(m_st == 3));
        chk({tag, ".state"}, 32'(state_o), 32'(m_st));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge and compare.
    task automatic cyc(input string tag, input bit r, e, v, input logic [31:0] x, y, z,
                       input bit p, c);
        rst = r; en = e; sample_vld = v; x_i = x; y_i = y; z_i = z; pop = p; clr_fail = c;
        model_step(r, e, v, whiten(x, y, z), p, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic smp(input string tag, input logic [31:0] x, y, z, input bit p);
        cyc(tag, 0, 1, 1, x, y, z, p, 0);
    endtask

    task automatic warm_to_run(input string tag);
        for (int i = 0; i < WARMUP; i++) smp(tag, $urandom, $urandom, $urandom, 0);
    endtask

    initial begin
        rst = 1; en = 0; sample_vld = 0; pop = 0; clr_fail = 0; x_i = 0; y_i = 0; z_i = 0;
        m_st = 0; m_warm = 0; m_rep = 0; m_last = 0; m_ovf = 0;

        cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset2", 1, 1, 1, 32'h1234, 0, 0, 1, 0);
        chk("reset_state_lit", 32'(state_o), 32'd0);

        // Warm-up: 16 samples, still WARMUP until the 16th lands
        cyc("enable", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WARMUP - 1; i++) smp("warmup", 32'h100 + i, 32'(i), 0, 0);
        chk("warmup_before_last", 32'(state_o), 32'd1);
        smp("warmup_last", 32'h5555, 0, 0, 0);
        chk("run_after_16", 32'(state_o), 32'd2);

        // Two pushes then in-order pops
        smp("t2_a", 32'h1, 32'h0001_0000, 32'h0, 0);
        smp("t2_b", 32'hDE78D681, 0, 0, 0);
        chk("t2_level2", 32'(level), 32'd2);
        chk("t2_head0", rd_data, 32'h0);
        cyc("t2_pop1", 0, 1, 0, 0, 0, 0, 1, 0);
        chk("t2_head1", rd_data, 32'hDE78D681);
        cyc("t2_pop2", 0, 1, 0, 0, 0, 0, 1, 0);
        chk("t2_empty", 32'(level), 32'd0);

        // Fill, overflow, then push+pop while full
        for (int i = 0; i < DEPTH; i++) smp("t3_fill", $urandom, $urandom, $urandom, 0);
        chk("t3_full", 32'(full), 32'd1);
        smp("t3_drop", $urandom, $urandom, $urandom, 0);
        chk("t3_ovf", 32'(overflow), 32'd1);
        smp("t3_pushpop", $urandom, $urandom, $urandom, 1);
        chk("t3_level8", 32'(level), 32'd8);

        // Drain, then repetition test trips on the 4th identical word
        for (int i = 0; i < DEPTH; i++) cyc("t4_drain", 0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < REP_LIMIT; i++) smp("t4_rep", 32'hA5A5A5A5, 0, 0, 0);
        chk("t4_fail", 32'(health_fail), 32'd1);
        chk("t4_flushed", 32'(level), 32'd0);
        cyc("t4_en0_stays", 0, 0, 1, 32'h77, 0, 0, 1, 0);
        smp("t4_ignored", $urandom, 0, 0, 1);
        cyc("t4_clr", 0, 1, 0, 0, 0, 0, 0, 1);
        chk("t4_clr_state", 32'(state_o), 32'd1);
        chk("t4_clr_ovf", 32'(overflow), 32'd0);

        // Empty-FIFO pop corner cases
        warm_to_run("t5_warm");
        cyc("t5_pop_empty", 0, 1, 0, 0, 0, 0, 1, 0);
        smp("t5_pushpop_empty", 32'hCAFEF00D, 0, 0, 1);
        chk("t5_level1", 32'(level), 32'd1);

        // Reset mid-operation, then en=0 mid-warm-up restarts the count
        for (int i = 0; i < 4; i++) smp("t6_fill", $urandom, $urandom, $urandom, 0);
        chk("t6_level5", 32'(level), 32'd5);
        cyc("t6_rst", 1, 1, 1, 32'h9, 0, 0, 1, 0);
        cyc("t6_en", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) smp("t6_warm_a", $urandom, $urandom, $urandom, 0);
        cyc("t6_disable", 0, 0, 1, 32'h3, 0, 0, 0, 0);
        cyc("t6_reen", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < WARMUP - 1; i++) smp("t6_warm_b", $urandom, $urandom, $urandom, 0);
        chk("t6_still_warm", 32'(state_o), 32'd1);
        smp("t6_last", $urandom, $urandom, $urandom, 0);
        chk("t6_run", 32'(state_o), 32'd2);

        // Randomized traffic with a narrow value set so repetitions occur
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rx, ry, rz;
            bit re, rv, rp, rc, rr;
            if ($urandom_range(0, 1) == 0) begin
                rx = $urandom_range(0, 2); ry = 0; rz = 0;
            end else begin
                rx = $urandom; ry = $urandom; rz = $urandom;
            end
            re = ($urandom_range(0, 15) != 0);
            rv = ($urandom_range(0, 9) < 6);
            rp = ($urandom_range(0, 2) == 0);
            rc = (m_st == 3) && ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 199) == 0);
            cyc("rand", rr, re, rv, rx, ry, rz, rp, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
